// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply and restoring divide with HI/LO result registers.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  state_e               state_q, state_d;
  logic                 div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic                 a_neg, b_neg, div0;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, trial;
  logic [2*WIDTH-1:0]   mul_nx, div_nx, prod;
  logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;
  assign a_neg   = op_i[0] & src1_i[WIDTH-1];
  assign b_neg   = op_i[0] & src2_i[WIDTH-1];
  assign a_mag   = a_neg ? -src1_i : src1_i;
  assign b_mag   = b_neg ? -src2_i : src2_i;
  assign div0    = op_i[1] && (src2_i == '0);
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? m_q : {WIDTH{1'b0}}};
  assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};
  // Trial subtract of the shifted partial remainder; a set top bit means it went negative.
  assign trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
  assign div_nx  = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod    = negq_q ? -acc_q : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];
  assign fix_hi  = div_q ? (negr_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
  assign fix_lo  = div_q ? (negq_q ? -quo : quo) : prod[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start_i && !flush_i) begin
        // Divide-by-zero preloads the raw dividend and all-ones so FIX writes them unchanged.
        div_d   = op_i[1];
        cnt_d   = '0;
        m_d     = op_i[1] ? b_mag : a_mag;
        acc_d   = div0 ? {src1_i, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
        negq_d  = !div0 && (a_neg ^ b_neg);
        negr_d  = !div0 && op_i[1] && a_neg;
        dz_d    = div0;
        state_d = div0 ? FIX : RUN;
      end
      RUN: if (flush_i) state_d = IDLE;
      else begin
        acc_d   = div_q ? div_nx : mul_nx;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIX : RUN;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;
endmodule
